servo_sequencer: RTL

//  Command-driven motion sequencer for the 3-bit servo position input of the
//  SG90 PWM generator. It accepts target positions over a valid/ready handshake.
//  It ramps the output one position code per STEP_TICKS cycles toward the

---
 rtl/servo_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/servo_sequencer.sv
// Command-driven motion sequencer for the SG90 servo position input.
// Ramps the position one code per STEP_TICKS toward a target, optionally dwells, then reports done.
module servo_sequencer #(
  parameter int unsigned STEP_TICKS = 1_200_000,
  parameter int unsigned HOLD_TICKS = 6_000_000,
  parameter int unsigned TICK_W     = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_target,
  input  logic                    cmd_hold,
  input  logic                    abort,
  output logic [2:0]              position,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned POS_W = 3;
  localparam logic [TICK_W-1:0] STEP_LAST = TICK_W'(STEP_TICKS - 1);
  localparam logic [TICK_W-1:0] HOLD_LAST = TICK_W'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state;
  logic [TICK_W-1:0]  timer;
  logic [POS_W-1:0]   target_q;
  logic               hold_q;
  logic [POS_W-1:0]   step_pos;

  // Position one code closer to the latched target; only applied on a step edge.
  assign step_pos = (target_q > position) ? position + POS_W'(1) : position - POS_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      position  <= '0;
      timer     <= '0;
      target_q  <= '0;
      hold_q    <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          // cmd_ready is always high here, so cmd_valid alone means accept.
          if (cmd_valid) begin
            target_q <= cmd_target;
            hold_q   <= cmd_hold;
            timer    <= '0;
            if (cmd_target != position) begin
              state     <= MOVE;
              busy      <= 1'b1;
              cmd_ready <= 1'b0;
            end else if (cmd_hold) begin
              state     <= HOLD;
              busy      <= 1'b1;
              cmd_ready <= 1'b0;
            end else begin
              done <= 1'b1;
            end
          end
        end

        MOVE: begin
          if (abort) begin
            state     <= IDLE;
            timer     <= '0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end else if (timer == STEP_LAST) begin
            timer    <= '0;
            position <= step_pos;
            if (step_pos == target_q) begin
              if (hold_q) begin
                state <= HOLD;
              end else begin
                state     <= IDLE;
                done      <= 1'b1;
                busy      <= 1'b0;
                cmd_ready <= 1'b1;
              end
            end
          end else begin
            timer <= timer + TICK_W'(1);
          end
        end

        HOLD: begin
          if (abort) begin
            state     <= IDLE;
            timer     <= '0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end else if (timer == HOLD_LAST) begin
            state     <= IDLE;
            timer     <= '0;
            done      <= 1'b1;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end else begin
            timer <= timer + TICK_W'(1);
          end
        end

        default: begin
          state     <= IDLE;
          timer     <= '0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
